rc_osc_ctrl: RTL
================

RC_OSC_CTRL -- requirements
Module: rc_osc_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, sets the width of the timeout, measurement-window and edge-count fields.
REQ-002 Parameter EDGE_W, default 8, sets the width of the min_edges lock threshold.
REQ-003 The block SHALL use one clock, with asynchronous, active-high reset.
REQ-004 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 en_req  input  1  software request to run the oscillator; level-sensitive.
REQ-007 timeout_cyc  input  CNT_W  startup timeout in clk cycles; 0 = no timeout.
REQ-008 min_edges  input  EDGE_W  oscillator rising edges required for lock; 0 is treated as 1.
REQ-009 meas_win  input  CNT_W  frequency-measurement window in clk cycles; 0 = measurement and loss detection disabled.
REQ-010 osc_dout  input  1  oscillator output, asynchronous to clk.
REQ-011 osc_ena  output  1  oscillator enable.
REQ-012 osc_ready  output  1  oscillator locked and running.
REQ-013 osc_fail  output  1  startup timeout or loss of oscillation.
REQ-014 meas_count  output  CNT_W  rising-edge count of the last completed window.
REQ-015 meas_valid  output  1  one-cycle pulse when meas_count updates.

Function
REQ-016 osc_dout SHALL pass through a 2-flop synchronizer followed by a delay flop. An edge is (sync2 & ~sync3).
REQ-017 If osc_dout rises before clk edge N, any counter that edge affects SHALL update at clk edge N+2.
REQ-018 The FSM SHALL have four states: IDLE, START, RUN and FAIL.
REQ-019 IDLE: osc_ena=0, osc_ready=0, osc_fail=0. When en_req=1, go to START, latch timeout_cyc into the timer and clear the edge counter.
REQ-020 START: osc_ena=1, osc_ready=0. Count edges. Decrement the timer each cycle when the latched timeout is nonzero.
REQ-021 START exit: when the edge count reaches max(min_edges,1), go to RUN, clear the window counter and the edge counter, and latch meas_win.
REQ-022 START exit: when the timer reaches 0 (latched timeout nonzero) with the lock condition unmet, go to FAIL.
REQ-023 If lock and timeout occur in the same cycle, lock SHALL win.
REQ-024 RUN: osc_ena=1, osc_ready=1, and the window counter increments each cycle.
REQ-025 RUN window end: when the window counter reaches the latched meas_win-1, load meas_count with the window's edge total, including an edge in that final cycle.
REQ-026 RUN window end (continued): pulse meas_valid for 1 cycle, then restart the window with a fresh meas_win latch.
REQ-027 RUN: if a completed window's total is 0, go to FAIL in the cycle after the window ends. meas_count=0 and meas_valid SHALL still pulse.
REQ-028 RUN: if the latched meas_win=0, no windows run, meas_valid stays 0, and loss detection is disabled.
REQ-029 FAIL: osc_ena=0, osc_ready=0, osc_fail=1. Stay in FAIL until en_req=0, then go to IDLE, which clears osc_fail.
REQ-030 In START or RUN, en_req=0 SHALL go to IDLE next cycle with priority over all other events. osc_ena and osc_ready SHALL drop with that transition.
REQ-031 Edge and window counters SHALL saturate at all-ones and never wrap.
REQ-032 meas_count SHALL hold its last value across IDLE and FAIL. It SHALL be overwritten only at a RUN window end.
REQ-033 osc_ena, osc_ready and osc_fail SHALL be registered outputs decoded from state.

Reset
REQ-034 While reset=1: state=IDLE, all outputs 0, synchronizer flops 0, and all counters and latches 0.
REQ-035 On reset deassertion, the FSM SHALL stay in IDLE until en_req=1 is sampled.
REQ-036 Reset asserted mid-START or mid-RUN SHALL drop osc_ena immediately (asynchronously).

Verification
REQ-037 Normal lock: clk 100 ns, oscillator model half-period 1000 ns with 224 us startup; en_req=1, timeout_cyc=4000, min_edges=4.
REQ-038 Normal lock response: RUN at about cycle 2320, osc_ready=1 and osc_fail=0.
REQ-039 Timeout: same setup with timeout_cyc=1000 -> osc_fail=1 at cycle 1001 after en_req, and osc_ena=0 from then on.
REQ-040 Measurement: after lock, meas_win=1000 -> meas_valid pulses every 1000 cycles, meas_count in 49..51.
REQ-041 Loss: in RUN, force osc_dout=0 -> FAIL after the first all-zero window, meas_valid with meas_count=0, osc_fail=1.
REQ-042 Loss recovery: after that FAIL, en_req=0 -> IDLE with osc_fail=0.
REQ-043 Abort and reset: en_req=0 mid-START -> IDLE next cycle, no FAIL. Reset mid-RUN -> all outputs 0 immediately, and meas_count=0.
REQ-044 Boundaries: min_edges=0 locks on the first edge; timeout_cyc=0 with osc_dout stuck low stays in START indefinitely, with no FAIL after 70000 cycles.

Source files
------------

// File: rtl/rc_osc_ctrl.sv
// RC oscillator controller: enables the oscillator, waits for lock or startup timeout,
// then measures edges per window and flags loss of oscillation.
module rc_osc_ctrl #(
  parameter int CNT_W  = 16,
  parameter int EDGE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_req,
  input  logic [CNT_W-1:0] timeout_cyc,
  input  logic [EDGE_W-1:0] min_edges,
  input  logic [CNT_W-1:0] meas_win,
  input  logic             osc_dout,
  output logic             osc_ena,
  output logic             osc_ready,
  output logic             osc_fail,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_valid,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    FAIL  = 2'd3
  } state_t;

  state_t state, next_state;

  logic             sync1, sync2, sync3;
  logic [CNT_W-1:0] timer;
  logic             tmo_en;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] win_lat;

  logic             osc_edge;
  logic [CNT_W-1:0] edge_inc;
  logic [CNT_W-1:0] thr;
  logic             lock;
  logic             tmo;
  logic             win_end;

  assign state_dbg = state;

  always_comb begin
    osc_edge = sync2 & ~sync3;
    edge_inc = (osc_edge && edge_cnt != '1) ? edge_cnt + CNT_W'(1) : edge_cnt;
    thr      = CNT_W'(min_edges);
    if (min_edges == '0) thr = CNT_W'(1);
    lock     = (edge_cnt >= thr);
    tmo      = tmo_en && (timer == '0);
    win_end  = (state == RUN) && en_req && (win_lat != '0) &&
               (win_cnt == win_lat - CNT_W'(1));
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (en_req) next_state = START;
      START: begin
        if (!en_req)   next_state = IDLE;
        else if (lock) next_state = RUN;
        else if (tmo)  next_state = FAIL;
      end
      RUN: begin
        if (!en_req)                          next_state = IDLE;
        else if (win_end && edge_inc == '0)   next_state = FAIL;
      end
      FAIL:  if (!en_req) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so they move together with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      osc_ena   <= 1'b0;
      osc_ready <= 1'b0;
      osc_fail  <= 1'b0;
    end else begin
      state     <= next_state;
      osc_ena   <= (next_state == START) || (next_state == RUN);
      osc_ready <= (next_state == RUN);
      osc_fail  <= (next_state == FAIL);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
      timer      <= '0;
      tmo_en     <= 1'b0;
      edge_cnt   <= '0;
      win_cnt    <= '0;
      win_lat    <= '0;
      meas_count <= '0;
      meas_valid <= 1'b0;
    end else begin
      sync1      <= osc_dout;
      sync2      <= sync1;
      sync3      <= sync2;
      meas_valid <= win_end;
      case (state)
        IDLE: begin
          if (en_req) begin
            // Loaded one short so the FAIL state lands exactly timeout_cyc+1 cycles after en_req.
            timer    <= timeout_cyc - CNT_W'(1);
            tmo_en   <= (timeout_cyc != '0);
            edge_cnt <= '0;
          end
        end
        START: begin
          edge_cnt <= edge_inc;
          if (tmo_en && timer != '0) timer <= timer - CNT_W'(1);
          if (en_req && lock) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
            win_lat  <= meas_win;
          end
        end
        RUN: begin
          edge_cnt <= edge_inc;
          if (win_end) begin
            meas_count <= edge_inc;
            win_cnt    <= '0;
            win_lat    <= meas_win;
            edge_cnt   <= '0;
          end else if (win_lat != '0 && win_cnt != '1) begin
            win_cnt <= win_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
